// File: rtl/arm_regfile_pkg.sv
// -----------------------------------------------------------------------------
// arm_regfile_pkg
// Shared constants and types for the integer register file and its write path.
//   REG_ADDR_W : register index width (decoder select width)
//   REG_DATA_W : register word width
//   ZERO_REG   : index of XZR; writes to it are architecturally discarded
//   reg_idx_t  : register index type
//   reg_word_t : register data word type
// -----------------------------------------------------------------------------
package arm_regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage : arm_regfile_pkg

// File: rtl/regfile_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at ptr_i and
// ascends, wrapping past NUM_REQ-1 back to 0; the first set request wins.
//   req_i       : request vector
//   ptr_i       : index holding highest priority this cycle
//   grant_o     : one-hot grant (all zero when no request)
//   idx_o       : encoded index of the granted requester
//   any_grant_o : high when some request was granted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_grant_o
);

    logic found_s;

    // Two passes: first the requesters at or above the pointer, then the
    // wrapped-around ones from index 0. The first hit in that order wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found_s && req_i[i] && (i >= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                idx_o      = PTR_W'(i);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found_s && req_i[i]) begin
                grant_o[i] = 1'b1;
                idx_o      = PTR_W'(i);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_grant_o = found_s;
    end

endmodule : rr_pick

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ writers. One registered write per cycle feeds the downstream 5-to-32
// write-address decoder. Writes to XZR are acked but never enabled.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   req      : per-requester write request, held until acked
//   req_addr : packed register indices, requester i uses slice i
//   req_data : packed write data, requester i uses slice i
//   ack      : combinational one-hot grant; transfer when req[i] & ack[i]
//   stall    : freezes arbitration (no ack, pointer held)
//   wr_sel   : registered decoder select
//   wr_en    : registered decoder enable
//   wr_data  : registered write data
//   busy     : registered; some request was pending and not acked last cycle
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import arm_regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      stall,
    output logic [ADDR_W-1:0]         wr_sel,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q,  ptr_d;
    logic [ADDR_W-1:0]  sel_q,  sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               en_q,   en_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   gidx_s;
    logic               any_grant_s;
    logic               xfer_s;
    logic [ADDR_W-1:0]  pick_addr_s;
    logic [DATA_W-1:0]  pick_data_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .idx_o       (gidx_s),
        .any_grant_o (any_grant_s)
    );

    // Grant gating: reset and stall both suppress ack in the same cycle.
    always_comb begin
        if (reset_n && !stall) begin
            ack    = grant_s;
            xfer_s = any_grant_s;
        end else begin
            ack    = '0;
            xfer_s = 1'b0;
        end
    end

    // Select the granted requester's address and data slices.
    always_comb begin
        pick_addr_s = '0;
        pick_data_s = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gidx_s == PTR_W'(i)) begin
                pick_addr_s = req_addr[i*ADDR_W +: ADDR_W];
                pick_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // Next state: pointer rotates past the winner; select/data hold when idle
    // while the enable always falls, so a stalled cycle issues no write.
    always_comb begin
        ptr_d  = ptr_q;
        sel_d  = sel_q;
        data_d = data_q;
        en_d   = 1'b0;
        busy_d = |(req & ~ack);
        if (xfer_s) begin
            sel_d  = pick_addr_s;
            data_d = pick_data_s;
            en_d   = (pick_addr_s != ADDR_W'(ZERO_REG));
            if (gidx_s == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State and output registers; reset drops any in-flight write at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            sel_q  <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            en_q   <= en_d;
            busy_q <= busy_d;
        end
    end

    assign wr_sel  = sel_q;
    assign wr_en   = en_q;
    assign wr_data = data_q;
    assign busy    = busy_q;

endmodule : regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port among NUM_REQ writers (ALU writeback, load unit, multiply unit, exception/LR write).
- Drives the 5-bit select and enable of the 5-to-32 write-address decoder and the 64-bit write data bus, one registered write per cycle.
- Discards writes to X31 (XZR) while still completing the requester handshake.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- ADDR_W, 5, register index width; decoder select width.
- DATA_W, 64, write data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; held until acked.
- req_addr  input  NUM_REQ*ADDR_W  packed register index; requester i uses slice i.
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i uses slice i.
- ack  output  NUM_REQ  one-hot grant; a transfer occurs on a cycle with req[i] & ack[i].
- stall  input  1  freezes arbitration; no ack, pointer held.
- wr_sel  output  ADDR_W  registered decoder select.
- wr_en  output  1  registered decoder enable.
- wr_data  output  DATA_W  registered write data.
- busy  output  1  registered; high if any req was pending and not acked last cycle.

Behaviour:
- Reset (async, reset_n=0): wr_sel=0, wr_en=0, wr_data=0, busy=0, priority pointer=0. ack is combinational and forced to 0 while reset_n=0.
- ack arbitration is combinational from req, stall and the pointer:
  - Search starts at the pointer index, ascending, wrapping modulo NUM_REQ.
  - The first i with req[i]=1 gets ack[i]=1.
  - At most one ack bit is high. ack=0 when stall=1 or req=0.
- Pointer update, on a rising edge with a transfer on requester g: pointer <= (g+1) mod NUM_REQ.
  - No transfer: pointer holds.
  - Wrap: g=NUM_REQ-1 gives pointer=0.
- Output register, latency 1:
  - On a transfer from g: wr_sel <= req_addr[g], wr_data <= req_data[g], wr_en <= (req_addr[g] != ZERO_REG).
  - No transfer: wr_en <= 0; wr_sel and wr_data hold their previous values.
- XZR: a request to index 31 is acked normally and rotates the pointer, but produces wr_en=0.
- Fairness: any continuously asserted request is acked within NUM_REQ cycles of non-stalled arbitration.
- Stall:
  - Stall takes effect the same cycle it is asserted.
  - The output register still updates to wr_en=0 during stall, so the write already in flight completes.
- Reset mid-operation: the in-flight write is lost (wr_en=0 immediately). Requesters must re-present after reset.
- No address-conflict detection: two requesters writing the same index on successive cycles both write, in grant order.
- busy <= |(req & ~ack) each cycle.

Decomposition:
- Shared package arm_regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=64, ZERO_REG=5'd31.
  - Typedef reg_idx_t (5-bit) and reg_word_t (64-bit).
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, pointer. Outputs: one-hot grant, encoded index, any_grant.
  - Instantiated once.
- The top module holds the pointer and output registers. The existing Decoder5to32 sits downstream, fed from wr_sel/wr_en, and is not instantiated here.

Test Plan:
1. Reset, then single writer: reset_n low -> all outputs 0. Then req=4'b0001, addr0=3, data0=64'hDEAD_BEEF -> ack=0001 in cycle 0; cycle 1 wr_en=1, wr_sel=3, wr_data=DEAD_BEEF; pointer=1.
2. Round-robin rotation: req=4'b1111 held for 8 cycles, pointer starting at 0 -> ack sequence 0001, 0010, 0100, 1000, 0001, ... with wr_sel following each requester's address one cycle later.
3. XZR discard: req=0010, addr1=31 -> ack=0010; next cycle wr_en=0, wr_sel=31; pointer=2.
4. Stall: req=1010 with stall=1 for 3 cycles -> ack=0 and wr_en=0 throughout, pointer unchanged. On stall release, ack=0010 if pointer<=1.
5. Wrap and skip: pointer=3, req=0101 -> ack=0001 (wraps past 3) and pointer becomes 1. Next cycle req=0100 -> ack=0100.
6. Async reset mid-write: assert reset_n=0 between edges while wr_en=1 -> wr_en drops to 0 immediately without a clock edge. After release, the first grant comes from requester 0.
